mult_control: RTL and testbench

- Sequencing controller for the 8-bit signed add-shift multiplier datapath.
- Drives the Load/Shift_En/Reset controls of the A and B register units, the X bit holder, and the 9-bit add/subtract unit.
- Reads the multiplier LSB (B[0]) each iteration and decides add, subtract or skip.
- Produces a fixed-length 8-iteration run per Run press, then holds until Run is released.

---
 rtl/mult_pkg.sv | 21 ++
 rtl/sync2.sv | 22 ++
 rtl/mult_control.sv | 121 ++++++++++++
 tb/tb_mult_control.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mult_pkg.sv
// Shared types and constants for the add-shift multiplier controller.
// Provides the controller state encoding and the default operand width.
package mult_pkg;

    localparam int MULT_N_BITS = 8;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        CLEAR,
        ADD,
        SHIFT,
        HOLD
    } ctrl_state_t;

    // Iteration counter width; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/sync2.sv
// One-bit two-flop synchronizer with synchronous active-high reset.
// Used for the controller's level inputs when MULT_CTRL_RUN_SYNC_EN is defined.
module sync2 (
    input  logic Clk,
    input  logic Reset,
    input  logic d,
    output logic q
);

    logic meta;

    always_ff @(posedge Clk) begin
        if (Reset) begin
            meta <= 1'b0;
            q    <= 1'b0;
        end else begin
            meta <= d;
            q    <= meta;
        end
    end

endmodule

// File: rtl/mult_control.sv
// Sequencing controller for the signed add-shift multiplier datapath.
// Optional MULT_CTRL_RUN_SYNC_EN puts Run and ClearA_LoadB through 2-flop synchronizers.
module mult_control
    import mult_pkg::*;
#(
    parameter int N_BITS = MULT_N_BITS
) (
    input  logic Clk,
    input  logic Reset,
    input  logic Run,
    input  logic ClearA_LoadB,
    input  logic M,
    output logic Clr_Ld,
    output logic Clear_AX,
    output logic Add,
    output logic Sub,
    output logic Shift,
    output logic Busy,
    output logic Done
);

    localparam int CNT_W = cnt_width(N_BITS);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(N_BITS - 1);

    logic run_req;
    logic load_req;

`ifdef MULT_CTRL_RUN_SYNC_EN
    sync2 u_sync_run (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (Run),
        .q     (run_req)
    );

    sync2 u_sync_load (
        .Clk   (Clk),
        .Reset (Reset),
        .d     (ClearA_LoadB),
        .q     (load_req)
    );
`else
    assign run_req  = Run;
    assign load_req = ClearA_LoadB;
`endif

    ctrl_state_t state, state_next;
    logic [CNT_W-1:0] cnt, cnt_next;
    logic last_iter;

    assign last_iter = (cnt == LAST_CNT);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state <= IDLE;
            cnt   <= '0;
        end else begin
            state <= state_next;
            cnt   <= cnt_next;
        end
    end

    // Add/Sub are the only Mealy outputs; the last iteration subtracts to fix the sign.
    always_comb begin
        state_next = state;
        cnt_next   = cnt;
        Clr_Ld     = 1'b0;
        Clear_AX   = 1'b0;
        Add        = 1'b0;
        Sub        = 1'b0;
        Shift      = 1'b0;
        Busy       = 1'b0;
        Done       = 1'b0;

        unique case (state)
            IDLE: begin
                if (run_req) begin
                    state_next = CLEAR;
                end else if (load_req) begin
                    state_next = LOAD;
                end
            end
            LOAD: begin
                Clr_Ld     = 1'b1;
                state_next = IDLE;
            end
            CLEAR: begin
                Clear_AX   = 1'b1;
                Busy       = 1'b1;
                cnt_next   = '0;
                state_next = ADD;
            end
            ADD: begin
                Busy       = 1'b1;
                Add        = M & ~last_iter;
                Sub        = M & last_iter;
                state_next = SHIFT;
            end
            SHIFT: begin
                Shift = 1'b1;
                Busy  = 1'b1;
                if (last_iter) begin
                    state_next = HOLD;
                end else begin
                    cnt_next   = cnt + CNT_W'(1);
                    state_next = ADD;
                end
            end
            HOLD: begin
                Done = 1'b1;
                if (!run_req) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_mult_control.sv
// Self-checking bench for mult_control: directed and random steps against a cycle-offset model.
// Honours MULT_CTRL_RUN_SYNC_EN by delaying the model's view of Run/ClearA_LoadB two cycles.
module tb_mult_control;
    import mult_pkg::*;

    localparam int N = MULT_N_BITS;
`ifdef MULT_CTRL_RUN_SYNC_EN
    localparam int LAT_EXTRA = 2;
`else
    localparam int LAT_EXTRA = 0;
`endif
    localparam int DONE_LAT = 2 * N + 2 + LAT_EXTRA;

    logic Clk = 1'b0;
    logic Reset, Run, ClearA_LoadB, M;
    logic Clr_Ld, Clear_AX, Add, Sub, Shift, Busy, Done;

    always #5 Clk = ~Clk;

    mult_control #(.N_BITS(N)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Run          (Run),
        .ClearA_LoadB (ClearA_LoadB),
        .M            (M),
        .Clr_Ld       (Clr_Ld),
        .Clear_AX     (Clear_AX),
        .Add          (Add),
        .Sub          (Sub),
        .Shift        (Shift),
        .Busy         (Busy),
        .Done         (Done)
    );

    int checks = 0;
    int errors = 0;
    bit live = 1'b0;

    // Model: mode 0 idle, 1 load pulse, 2 run in progress; t counts cycles since the run began.
    int mode = 0;
    int t = 0;
    logic s1_run = 1'b0, s2_run = 1'b0, s1_clr = 1'b0, s2_clr = 1'b0;

    int step_idx = 0;
    int run_start = 0;
    int first_done = -1;
    int n_clrld, n_clearax, n_add, n_sub, n_shift, n_busy, n_done, n_both;

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic check_int(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_tally();
        n_clrld = 0; n_clearax = 0; n_add = 0; n_sub = 0;
        n_shift = 0; n_busy = 0; n_done = 0; n_both = 0;
        first_done = -1;
        run_start = step_idx;
    endtask

    task automatic checkOutput();
        bit act, even;
        int i;
        act  = (mode == 2);
        even = (t % 2 == 0);
        i    = (t - 2) / 2;
        check_bit("Clr_Ld",   Clr_Ld,   mode == 1);
        check_bit("Clear_AX", Clear_AX, act && t == 1);
        check_bit("Busy",     Busy,     act && t >= 1 && t <= 2 * N + 1);
        check_bit("Shift",    Shift,    act && !even && t >= 3 && t <= 2 * N + 1);
        check_bit("Add",      Add,      act && even && t >= 2 && t <= 2 * N && M === 1'b1 && i < N - 1);
        check_bit("Sub",      Sub,      act && even && t >= 2 && t <= 2 * N && M === 1'b1 && i == N - 1);
        check_bit("Done",     Done,     act && t == 2 * N + 2);
        if (Clr_Ld === 1'b1)   n_clrld++;
        if (Clear_AX === 1'b1) n_clearax++;
        if (Add === 1'b1)      n_add++;
        if (Sub === 1'b1)      n_sub++;
        if (Shift === 1'b1)    n_shift++;
        if (Busy === 1'b1)     n_busy++;
        if (Done === 1'b1)     n_done++;
        if (Add === 1'b1 && Sub === 1'b1) n_both++;
        if (Done === 1'b1 && first_done < 0) first_done = step_idx - run_start;
    endtask

    task automatic model_update(input logic r, input logic c, input logic rs);
        logic er, ec;
`ifdef MULT_CTRL_RUN_SYNC_EN
        er = s2_run;
        ec = s2_clr;
        if (rs) begin
            s1_run = 1'b0; s2_run = 1'b0; s1_clr = 1'b0; s2_clr = 1'b0;
        end else begin
            s2_run = s1_run; s1_run = r;
            s2_clr = s1_clr; s1_clr = c;
        end
`else
        er = r;
        ec = c;
`endif
        if (rs) begin
            mode = 0;
            t    = 0;
        end else begin
            case (mode)
                0: begin
                    if (er) begin
                        mode = 2;
                        t    = 1;
                    end else if (ec) begin
                        mode = 1;
                    end
                end
                1: mode = 0;
                default: begin
                    if (t < 2 * N + 2) t++;
                    else if (!er) mode = 0;
                end
            endcase
        end
    endtask

    task automatic applyStimulus(input logic r, input logic c, input logic mm, input logic rs);
        Run = r; ClearA_LoadB = c; M = mm; Reset = rs;
        #1;
        if (live) checkOutput();
        @(posedge Clk);
        model_update(r, c, rs);
        if (rs) live = 1'b1;
        step_idx++;
        #1;
    endtask

    initial begin
        // Reset held with Run high, then released with Run still high.
        repeat (3) applyStimulus(1'b1, 1'b0, 1'b0, 1'b1);
        reset_tally();
        for (int k = 0; k < 2 * N + 6; k++) applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        check_int("first_run_shifts", n_shift, N);
        check_int("first_run_latency", first_done, DONE_LAT);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);

        // Single load request in IDLE.
        reset_tally();
        applyStimulus(1'b0, 1'b1, 1'b0, 1'b0);
        repeat (4) applyStimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_int("load_pulse_count", n_clrld, 1);

        // Run pulse with M=0; load request while busy must be ignored.
        reset_tally();
        applyStimulus(1'b1, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k < 2 * N + 6; k++) applyStimulus(1'b0, k == 6, 1'b0, 1'b0);
        check_int("m0_clear_ax", n_clearax, 1);
        check_int("m0_shifts", n_shift, N);
        check_int("m0_adds", n_add, 0);
        check_int("m0_subs", n_sub, 0);
        check_int("m0_clr_ld_while_busy", n_clrld, 0);
        check_int("m0_busy_cycles", n_busy, 2 * N + 1);
        check_int("m0_done_cycles", n_done, 1);
        check_int("m0_latency", first_done, DONE_LAT);

        // Run held for 40 cycles with M=1: one run, sign-correcting subtract last.
        reset_tally();
        repeat (40) applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        check_int("m1_adds", n_add, N - 1);
        check_int("m1_subs", n_sub, 1);
        check_int("m1_shifts", n_shift, N);
        check_int("m1_single_run", n_clearax, 1);
        check_int("m1_add_sub_overlap", n_both, 0);
        check_int("m1_done_held", n_done, 40 - DONE_LAT);
        repeat (3) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);

        // Second press with random multiplier bits.
        reset_tally();
        applyStimulus(1'b1, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        repeat (2 * N + 5) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        check_int("second_run_shifts", n_shift, N);
        check_int("second_run_addsub_bound", int'(n_add + n_sub <= N), 1);

        // Reset in the middle of a run, then a full run afterwards.
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (8) applyStimulus(1'b0, 1'b0, 1'($urandom_range(0, 1)), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b1);
        reset_tally();
        applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_int("post_reset_quiet", n_busy + n_done + n_add + n_sub + n_shift, 0);
        reset_tally();
        applyStimulus(1'b1, 1'b0, 1'b1, 1'b0);
        repeat (2 * N + 5) applyStimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_int("post_reset_shifts", n_shift, N);
        check_int("post_reset_latency", first_done, DONE_LAT);

        // Random soak against the model.
        for (int k = 0; k < 400; k++) begin
            applyStimulus(1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 3) == 0),
                          1'($urandom_range(0, 1)),
                          1'($urandom_range(0, 63) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
